lcd_frame_ctrl: RTL

Sequencer for the 2-line character LCD in the Log2048 top. It runs the power-on init command sequence, then copies a 32-character frame (2 lines × 16) from the game's text buffer to the panel on request. It drives LCD_E/RS/RW/DATA directly, and each refresh is bracketed by a busy/done handshake toward the game core.

---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/lcd_slot_timer.sv | 46 ++++
 rtl/lcd_frame_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the character LCD frame sequencer.
// Holds the FSM state enum, HD44780 command bytes and frame geometry.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_POR,
        S_INIT,
        S_IDLE,
        S_ADDR1,
        S_LINE1,
        S_ADDR2,
        S_LINE2
    } lcd_state_t;

    localparam logic [7:0] CMD_FUNC    = 8'h38;
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_LINE1   = 8'h80;
    localparam logic [7:0] CMD_LINE2   = 8'hC0;

    localparam int FRAME_CHARS = 32;
    localparam int LINE_CHARS  = FRAME_CHARS / 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Power-on command order; index 2 is the slow clear.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_FUNC;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_CLEAR;
            default: cmd = CMD_ENTRY;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_slot_timer.sv
// Slot timer: counts one LCD write slot and produces the E window.
// Ports: load (start slot), slot_last (length-1), e_window, slot_end.
module lcd_slot_timer #(
    parameter int W      = 5,
    parameter int E_HIGH = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] slot_last,
    output logic         e_window,
    output logic         slot_end
);

    localparam logic [W-1:0] ONE    = W'(1);
    localparam logic [W-1:0] E_FROM = W'(1);
    localparam logic [W-1:0] E_TO   = W'(E_HIGH);

    logic [W-1:0] cnt;
    logic         armed;

    // The terminal count is passed in rather than the length, so a
    // power-of-two slot still fits the counter width.
    assign slot_end = (cnt == slot_last);

    // Out of reset the counter times the power-on wait; armed stays
    // low until the first real slot so no strobe appears during it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            armed    <= 1'b0;
            e_window <= 1'b0;
        end else if (load) begin
            cnt      <= '0;
            armed    <= 1'b1;
            e_window <= 1'b0;
        end else if (!slot_end) begin
            cnt      <= cnt + ONE;
            // cnt in [1, E_HIGH] now means c2 .. c2+E_HIGH-1 next.
            e_window <= armed && (cnt >= E_FROM) && (cnt <= E_TO);
        end else begin
            e_window <= 1'b0;
        end
    end

endmodule

// File: rtl/lcd_frame_ctrl.sv
// Character LCD sequencer: power-on init, then 2x16 frame refreshes.
// Ports: refresh_req/busy/done to the game core, char_addr/char_data
// to the text buffer, LCD_E/RS/RW/DATA straight to the panel.
module lcd_frame_ctrl
    import lcd_pkg::*;
#(
    parameter int POR_CYCLES   = 1000000,
    parameter int STEP_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 100000,
    parameter int E_HIGH       = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       refresh_req,
    output logic [4:0] char_addr,
    input  logic [7:0] char_data,
    output logic       busy,
    output logic       done,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    localparam int CW = $clog2(max_int(POR_CYCLES, CLEAR_CYCLES));

    localparam logic [CW-1:0] POR_LAST   = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] STEP_LAST  = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYCLES - 1);

    localparam logic [4:0] LINE1_END = 5'(LINE_CHARS - 1);
    localparam logic [4:0] CHAR_END  = 5'(FRAME_CHARS - 1);
    localparam logic [4:0] ADDR_ONE  = 5'd1;

    lcd_state_t    state;
    logic [1:0]    init_idx;
    logic          pending;
    logic          c0_q;
    logic          load;
    logic          pend_any;
    logic          last_char;
    logic          slot_end;
    logic          e_window;
    logic [CW-1:0] slot_last;

    assign pend_any  = pending | refresh_req;
    assign last_char = (char_addr == CHAR_END);
    assign LCD_RW    = 1'b0;
    // Timer flop with async reset, so E drops the moment rst_n falls.
    assign LCD_E     = e_window;

    lcd_slot_timer #(
        .W      (CW),
        .E_HIGH (E_HIGH)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .slot_last (slot_last),
        .e_window  (e_window),
        .slot_end  (slot_end)
    );

    always_comb begin
        slot_last = STEP_LAST;
        if (state == S_POR) begin
            slot_last = POR_LAST;
        end else if (state == S_INIT && init_idx == 2'd2) begin
            slot_last = CLEAR_LAST;
        end
    end

    // A new slot starts exactly when the current one ends, except
    // when the sequence drops into idle.
    always_comb begin
        load = 1'b0;
        unique case (state)
            S_POR, S_ADDR1, S_LINE1, S_ADDR2:
                load = slot_end;
            S_INIT:
                load = slot_end && (init_idx != 2'd3 || pend_any);
            S_IDLE:
                load = pend_any;
            S_LINE2:
                load = slot_end && (!last_char || pend_any);
            default:
                load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_POR;
            init_idx  <= 2'd0;
            pending   <= 1'b1;
            c0_q      <= 1'b0;
            char_addr <= 5'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_DATA  <= 8'h00;
        end else begin
            done <= 1'b0;
            c0_q <= load;

            if (refresh_req && busy) begin
                pending <= 1'b1;
            end

            // End of c0: capture the byte for this slot.
            if (c0_q) begin
                unique case (state)
                    S_INIT: begin
                        LCD_DATA <= init_cmd(init_idx);
                        LCD_RS   <= 1'b0;
                    end
                    S_ADDR1: begin
                        LCD_DATA <= CMD_LINE1;
                        LCD_RS   <= 1'b0;
                    end
                    S_ADDR2: begin
                        LCD_DATA <= CMD_LINE2;
                        LCD_RS   <= 1'b0;
                    end
                    S_LINE1, S_LINE2: begin
                        LCD_DATA <= char_data;
                        LCD_RS   <= 1'b1;
                    end
                    default: ;
                endcase
            end

            unique case (state)
                S_POR: begin
                    if (slot_end) begin
                        state <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (slot_end) begin
                        if (init_idx != 2'd3) begin
                            init_idx <= init_idx + 2'd1;
                        end else if (pend_any) begin
                            state   <= S_ADDR1;
                            pending <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_IDLE: begin
                    if (pend_any) begin
                        state   <= S_ADDR1;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_ADDR1: begin
                    if (slot_end) begin
                        state <= S_LINE1;
                    end
                end
                S_LINE1: begin
                    if (slot_end) begin
                        if (char_addr == LINE1_END) begin
                            state <= S_ADDR2;
                        end else begin
                            char_addr <= char_addr + ADDR_ONE;
                        end
                    end
                end
                S_ADDR2: begin
                    if (slot_end) begin
                        state     <= S_LINE2;
                        char_addr <= char_addr + ADDR_ONE;
                    end
                end
                S_LINE2: begin
                    if (slot_end) begin
                        // 31 + 1 wraps to 0, ready for the next frame.
                        char_addr <= char_addr + ADDR_ONE;
                        if (last_char) begin
                            done <= 1'b1;
                            if (pend_any) begin
                                state   <= S_ADDR1;
                                pending <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= S_POR;
                end
            endcase
        end
    end

endmodule
